// File: rtl/reflet_ram_arb_pkg.sv
// reflet_ram_arbiter shared definitions.
// FSM state encodings and requester port indices.
package reflet_ram_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } arb_state_t;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/reflet_ram_arb_if.sv
// Requester and RAM side bundle of reflet_ram_arbiter.
// master = requesters plus RAM, slave = the arbiter.
interface reflet_ram_arb_if #(
    parameter int addrSize = 7,
    parameter int wordsize = 8
);
    logic                req0;
    logic                req1;
    logic                we0;
    logic                we1;
    logic [addrSize-1:0] addr0;
    logic [addrSize-1:0] addr1;
    logic [wordsize:0]   wdata0;
    logic [wordsize:0]   wdata1;
    logic                ack0;
    logic                ack1;
    logic [wordsize:0]   rdata0;
    logic [wordsize:0]   rdata1;
    logic                ram_enable;
    logic [addrSize-1:0] ram_addr;
    logic [wordsize:0]   ram_data_in;
    logic                ram_write_en;
    logic [wordsize:0]   ram_data_out;
    logic                busy;
    logic                grant;

    modport master (
        output req0, req1, we0, we1,
        output addr0, addr1, wdata0, wdata1,
        input  ack0, ack1, rdata0, rdata1,
        input  ram_enable, ram_addr,
        input  ram_data_in, ram_write_en,
        output ram_data_out,
        input  busy, grant
    );

    modport slave (
        input  req0, req1, we0, we1,
        input  addr0, addr1, wdata0, wdata1,
        output ack0, ack1, rdata0, rdata1,
        output ram_enable, ram_addr,
        output ram_data_in, ram_write_en,
        input  ram_data_out,
        output busy, grant
    );

endinterface

// File: rtl/reflet_ram_arbiter_rr_arb2.sv
// Two-way winner select; round-robin on last winner, or fixed
// priority to port 0 when REFLET_RAM_ARB_FIXED_PRIO_EN is defined.
module reflet_rr_arb2
    import reflet_ram_arb_pkg::*;
(
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_i,
    output logic win_o
);

`ifdef REFLET_RAM_ARB_FIXED_PRIO_EN
    logic unused_last;
    assign unused_last = last_i;

    always_comb begin
        win_o = PORT0;
        if (!req0_i && req1_i) win_o = PORT1;
    end
`else
    always_comb begin
        win_o = PORT0;
        if (req0_i && req1_i) win_o = ~last_i;
        else if (req1_i)      win_o = PORT1;
    end
`endif

endmodule

// File: rtl/reflet_ram_arbiter.sv
// Shares one reflet_ram between two request/ack ports.
// REFLET_RAM_ARB_FIXED_PRIO_EN selects fixed priority over round-robin.
module reflet_ram_arbiter
    import reflet_ram_arb_pkg::*;
#(
    parameter int addrSize = 7,
    parameter int wordsize = 8
) (
    input  logic clk,
    input  logic reset,
    reflet_ram_arb_if.slave bus
);

    arb_state_t          state_q, state_d;
    logic                grant_q, grant_d;
    logic [addrSize-1:0] addr_q, addr_d;
    logic                we_q, we_d;
    logic [wordsize:0]   wdata_q, wdata_d;
    logic [wordsize:0]   rdata0_q, rdata0_d;
    logic [wordsize:0]   rdata1_q, rdata1_d;
    logic                win;
    logic                last_w;
    logic                any_req;
    logic                ack0, ack1;
    logic                ram_en, ram_we;
    logic [addrSize-1:0] ram_addr;
    logic [wordsize:0]   ram_din;

    assign any_req = bus.req0 | bus.req1;

`ifdef REFLET_RAM_ARB_FIXED_PRIO_EN
    assign last_w = PORT1;
`else
    logic last_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                         last_q <= PORT1;
        else if (state_q == IDLE && any_req) last_q <= win;
    end

    assign last_w = last_q;
`endif

    reflet_rr_arb2 u_arb (
        .req0_i (bus.req0),
        .req1_i (bus.req1),
        .last_i (last_w),
        .win_o  (win)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            grant_q  <= PORT0;
            addr_q   <= '0;
            we_q     <= 1'b0;
            wdata_q  <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            addr_q   <= addr_d;
            we_q     <= we_d;
            wdata_q  <= wdata_d;
            rdata0_q <= rdata0_d;
            rdata1_q <= rdata1_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        grant_d  = grant_q;
        addr_d   = addr_q;
        we_d     = we_q;
        wdata_d  = wdata_q;
        rdata0_d = rdata0_q;
        rdata1_d = rdata1_q;
        ack0     = 1'b0;
        ack1     = 1'b0;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        unique case (state_q)
            IDLE: begin
                if (any_req) begin
                    state_d = ADDR;
                    grant_d = win;
                    if (win == PORT1) begin
                        addr_d  = bus.addr1;
                        we_d    = bus.we1;
                        wdata_d = bus.wdata1;
                    end else begin
                        addr_d  = bus.addr0;
                        we_d    = bus.we0;
                        wdata_d = bus.wdata0;
                    end
                end
            end
            ADDR: begin
                ram_en   = 1'b1;
                ram_addr = addr_q;
                ram_din  = wdata_q;
                ram_we   = we_q;
                state_d  = DATA;
            end
            DATA: begin
                ram_en   = 1'b1;
                ram_addr = addr_q;
                state_d  = DONE;
            end
            DONE: begin
                // RAM read register holds the post-write word only now
                ram_en   = 1'b1;
                ram_addr = addr_q;
                state_d  = IDLE;
                if (grant_q == PORT1) begin
                    ack1     = 1'b1;
                    rdata1_d = bus.ram_data_out;
                end else begin
                    ack0     = 1'b1;
                    rdata0_d = bus.ram_data_out;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.ack0         = ack0;
    assign bus.ack1         = ack1;
    assign bus.rdata0       = rdata0_q;
    assign bus.rdata1       = rdata1_q;
    assign bus.ram_enable   = ram_en;
    assign bus.ram_addr     = ram_addr;
    assign bus.ram_data_in  = ram_din;
    assign bus.ram_write_en = ram_we;
    assign bus.busy         = (state_q != IDLE);
    assign bus.grant        = grant_q;

endmodule

// File: tb/tb_reflet_ram_arbiter.sv
// Directed bench for reflet_ram_arbiter with a behavioural reflet_ram.
// Honours REFLET_RAM_ARB_FIXED_PRIO_EN for the arbitration expectations.
`timescale 1ns/1ps
module tb_reflet_ram_arbiter;

    localparam int AW = 8;
    localparam int WW = 8;
    localparam int RAM_WORDS = 128;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int n_cmp = 0;
    int n_err = 0;
    int ack0_cnt = 0;
    int ack1_cnt = 0;

    always #5 clk = ~clk;

    reflet_ram_arb_if #(.addrSize(AW), .wordsize(WW)) bus ();

    reflet_ram_arbiter #(.addrSize(AW), .wordsize(WW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    logic [WW:0] mem [0:RAM_WORDS-1];
    logic [WW:0] rd_q;

    initial for (int i = 0; i < RAM_WORDS; i++) mem[i] = '0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            rd_q <= '0;
        end else if (bus.ram_enable) begin
            if (bus.ram_write_en && !bus.ram_addr[7])
                mem[bus.ram_addr[6:0]] <= bus.ram_data_in;
            rd_q <= bus.ram_addr[7] ? '0 : mem[bus.ram_addr[6:0]];
        end
    end

    assign bus.ram_data_out = bus.ram_enable ? rd_q : '0;

    always @(negedge clk) begin
        if (bus.ack0 === 1'b1) ack0_cnt++;
        if (bus.ack1 === 1'b1) ack1_cnt++;
    end

`define CHK(TAG, OBS, EXP) \
    begin \
        n_cmp++; \
        assert ((OBS) === (EXP)) else begin \
            n_err++; \
            $error("FAIL %s: observed %0h expected %0h", TAG, OBS, EXP); \
        end \
    end

    task automatic chk_rst(input string tag,
                           input logic [WW:0] obs,
                           input logic [WW:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $error("FAIL reset %s: observed %0h expected %0h",
                   tag, obs, exp);
        end
    endtask

    task automatic access(input logic p, input logic w,
                          input logic [AW-1:0] a, input logic [WW:0] d,
                          input logic [WW:0] exp_rd, input string tag);
        int lat;
        string t;
        logic [WW:0] rd;
        @(posedge clk); #1;
        if (p) begin
            bus.req1 = 1'b1; bus.we1 = w; bus.addr1 = a; bus.wdata1 = d;
        end else begin
            bus.req0 = 1'b1; bus.we0 = w; bus.addr0 = a; bus.wdata0 = d;
        end
        lat = 0;
        for (int c = 1; c <= 8; c++) begin
            @(posedge clk); #1;
            if ((p ? bus.ack1 : bus.ack0) === 1'b1) begin
                lat = c;
                break;
            end
        end
        n_cmp++;
        if (lat == 0) begin
            n_err++;
            $error("FAIL %s: wait for ack expired", tag);
        end
        t = {tag, " latency"};
        `CHK(t, lat, 3)
        t = {tag, " grant"};
        `CHK(t, bus.grant, p)
        t = {tag, " other ack"};
        `CHK(t, (p ? bus.ack0 : bus.ack1), 1'b0)
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        @(posedge clk); #1;
        rd = p ? bus.rdata1 : bus.rdata0;
        t = {tag, " rdata"};
        `CHK(t, rd, exp_rd)
    endtask

    task automatic do_reset();
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        int a0, a1, seen, order;
        logic g [0:3];
        logic exp_g [0:3];

        bus.req0 = 0; bus.req1 = 0; bus.we0 = 0; bus.we1 = 0;
        bus.addr0 = '0; bus.addr1 = '0;
        bus.wdata0 = '0; bus.wdata1 = '0;

        do_reset();
        chk_rst("busy", bus.busy, '0);
        chk_rst("grant", bus.grant, '0);
        chk_rst("ack0", bus.ack0, '0);
        chk_rst("ack1", bus.ack1, '0);
        chk_rst("rdata0", bus.rdata0, 9'h000);
        chk_rst("rdata1", bus.rdata1, 9'h000);
        chk_rst("ram_enable", bus.ram_enable, '0);
        chk_rst("ram_write_en", bus.ram_write_en, '0);
        chk_rst("ram_addr", bus.ram_addr, '0);
        chk_rst("ram_data_in", bus.ram_data_in, '0);

        a0 = ack0_cnt;
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd5;
        @(posedge clk); #1;
        @(posedge clk); #1;
        `CHK("abort busy in DATA", bus.busy, 1'b1)
        `CHK("abort en in DATA", bus.ram_enable, 1'b1)
        #2 reset = 1'b0;
        bus.req0 = 1'b0;
        #1;
        `CHK("abort busy", bus.busy, 1'b0)
        `CHK("abort ram_enable", bus.ram_enable, 1'b0)
        `CHK("abort ack0", bus.ack0, 1'b0)
        @(posedge clk); #1 reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        `CHK("abort rdata0", bus.rdata0, 9'h000)
        `CHK("abort ack0 count", ack0_cnt - a0, 0)

        a1 = ack1_cnt;
        access(1'b0, 1'b1, 8'd5, 9'h1A5, 9'h1A5, "p0 wr5");
        `CHK("mem5", mem[5], 9'h1A5)
        access(1'b0, 1'b0, 8'd5, 9'h000, 9'h1A5, "p0 rd5");
        `CHK("ack1 never", ack1_cnt - a1, 0)

        access(1'b1, 1'b1, 8'd200, 9'h155, 9'h000, "p1 wr200");
        access(1'b1, 1'b0, 8'd127, 9'h000, 9'h000, "p1 rd127");
        `CHK("mem127", mem[127], 9'h000)

        @(posedge clk); #1;
        bus.req1 = 1'b1; bus.we1 = 1'b1;
        bus.addr1 = 8'd3; bus.wdata1 = 9'h0FF;
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd3;
        seen = 0; order = 0;
        for (int c = 0; c < 20 && seen < 2; c++) begin
            @(posedge clk); #1;
            if (bus.ack1 === 1'b1) begin
                bus.req1 = 1'b0;
                seen++;
            end else if (bus.ack0 === 1'b1) begin
                bus.req0 = 1'b0;
                if (seen == 1) order = 1;
                seen++;
            end
        end
        if (seen < 2) begin
            n_err++;
            $error("FAIL queue: wait for acks expired (%0d seen)", seen);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        @(posedge clk); #1;
        `CHK("queue acks", seen, 2)
        `CHK("queue order", order, 1)
        `CHK("queue rdata0", bus.rdata0, 9'h0FF)
        `CHK("queue rdata1", bus.rdata1, 9'h0FF)

        do_reset();
`ifdef REFLET_RAM_ARB_FIXED_PRIO_EN
        exp_g[0] = 0; exp_g[1] = 0; exp_g[2] = 0; exp_g[3] = 0;
`else
        exp_g[0] = 0; exp_g[1] = 1; exp_g[2] = 0; exp_g[3] = 1;
`endif
        @(posedge clk); #1;
        bus.req0 = 1'b1; bus.we0 = 1'b0; bus.addr0 = 8'd5;
        bus.req1 = 1'b1; bus.we1 = 1'b0; bus.addr1 = 8'd3;
        seen = 0;
        for (int i = 0; i < 4; i++) g[i] = 1'bx;
        for (int c = 0; c < 40 && seen < 4; c++) begin
            @(posedge clk); #1;
            if (bus.ack0 === 1'b1) begin
                g[seen] = 1'b0; seen++;
            end else if (bus.ack1 === 1'b1) begin
                g[seen] = 1'b1; seen++;
            end
        end
        if (seen < 4) begin
            n_err++;
            $error("FAIL rr: wait for acks expired (%0d seen)", seen);
        end
        bus.req0 = 1'b0; bus.req1 = 1'b0;
        `CHK("rr acks", seen, 4)
        `CHK("rr grant0", g[0], exp_g[0])
        `CHK("rr grant1", g[1], exp_g[1])
        `CHK("rr grant2", g[2], exp_g[2])
        `CHK("rr grant3", g[3], exp_g[3])
        repeat (2) @(posedge clk);
        #1;
        `CHK("rr idle", bus.busy, 1'b0)

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
